// File: rtl/regfile_checker.sv
// regfile_checker
//   Register-file scoreboard for CPU simulation tops and on-board test builds.
//   After a start pulse it waits for the CPU to halt, which is either a pc that
//   stays unchanged for HALT_STABLE samples or a cycle timeout. It then scans a
//   programmable table of (register index, expected value) entries through a
//   read port into the CPU register file and reports the outcome.
//
// Ports
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle pulse, accepted in IDLE or DONE
//   pc              CPU program counter, sampled every cycle
//   cfg_we/idx/en/addr/data  table write port, honoured in IDLE or DONE only
//   rf_raddr        read address into the CPU register file
//   rf_rdata        read data, valid one cycle after rf_raddr
//   busy, done      status (busy in WAIT/SCAN, done in DONE)
//   pass            err_count==0 and no timeout, meaningful when done
//   timed_out       halt was forced by the cycle timeout
//   err_count       mismatching enabled entries (saturates at NCHECK)
//   first_err_*     register index, read value and expected value of the
//                   first mismatch of the run
module regfile_checker #(
  parameter int XLEN           = 32,
  parameter int NREG           = 32,
  parameter int NCHECK         = 8,
  parameter int HALT_STABLE    = 4,
  parameter int TIMEOUT_CYCLES = 100000,
  localparam int RW = $clog2(NREG),
  localparam int IW = (NCHECK > 1) ? $clog2(NCHECK) : 1,
  localparam int CW = $clog2(NCHECK + 1)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [XLEN-1:0] pc,
  input  logic            cfg_we,
  input  logic [IW-1:0]   cfg_idx,
  input  logic            cfg_en,
  input  logic [RW-1:0]   cfg_addr,
  input  logic [XLEN-1:0] cfg_data,
  output logic [RW-1:0]   rf_raddr,
  input  logic [XLEN-1:0] rf_rdata,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic            timed_out,
  output logic [CW-1:0]   err_count,
  output logic [RW-1:0]   first_err_addr,
  output logic [XLEN-1:0] first_err_got,
  output logic [XLEN-1:0] first_err_exp
);

  localparam int TCW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int SW  = (HALT_STABLE > 2) ? $clog2(HALT_STABLE) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SCAN, S_DONE} state_t;

  state_t            state, state_next;
  logic [XLEN-1:0]   pc_prev;
  logic [TCW-1:0]    cycle_cnt;
  logic [SW-1:0]     stable_cnt;
  logic [CW-1:0]     scan_cnt;

  logic              tab_en   [NCHECK];
  logic [RW-1:0]     tab_addr [NCHECK];
  logic [XLEN-1:0]   tab_data [NCHECK];

  logic              idle_like;
  logic              cfg_wr;
  logic              pc_same;
  logic              halt;
  logic              tmo_hit;
  logic              scan_last;
  logic [IW-1:0]     cmp_idx;
  logic [IW-1:0]     iss_idx;
  logic              mismatch;

  assign idle_like = (state == S_IDLE) || (state == S_DONE);
  assign cfg_wr    = idle_like && cfg_we;
  assign pc_same   = (pc == pc_prev);
  // HALT_STABLE equal samples means HALT_STABLE-1 equal comparisons; the last
  // one is happening in this cycle when the counter already holds -2.
  assign halt      = (state == S_WAIT) && pc_same &&
                     (stable_cnt == SW'(HALT_STABLE - 2));
  assign tmo_hit   = (state == S_WAIT) && (cycle_cnt == TCW'(TIMEOUT_CYCLES - 1));
  assign scan_last = (scan_cnt == CW'(NCHECK));

  // Compare stage works on the entry issued one scan cycle earlier.
  assign cmp_idx   = IW'(scan_cnt - CW'(1));
  assign iss_idx   = IW'(scan_cnt + CW'(1));
  assign mismatch  = (state == S_SCAN) && (scan_cnt != '0) && tab_en[cmp_idx] &&
                     (rf_rdata != tab_data[cmp_idx]);

  assign busy = (state == S_WAIT) || (state == S_SCAN);
  assign done = (state == S_DONE);
  assign pass = done && (err_count == '0) && !timed_out;

  // Expected-value table; reset erases every entry.
  generate
    for (genvar gi = 0; gi < NCHECK; gi++) begin : g_tab
      always_ff @(posedge clk) begin
        if (rst) begin
          tab_en[gi]   <= 1'b0;
          tab_addr[gi] <= '0;
          tab_data[gi] <= '0;
        end else if (cfg_wr && (cfg_idx == IW'(gi))) begin
          tab_en[gi]   <= cfg_en;
          tab_addr[gi] <= cfg_addr;
          tab_data[gi] <= cfg_data;
        end
      end
    end
  endgenerate

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_next = S_WAIT;
      S_WAIT:         if (halt || tmo_hit) state_next = S_SCAN;
      S_SCAN:         if (scan_last) state_next = S_DONE;
      default:        state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      pc_prev        <= '0;
      cycle_cnt      <= '0;
      stable_cnt     <= '0;
      scan_cnt       <= '0;
      rf_raddr       <= '0;
      timed_out      <= 1'b0;
      err_count      <= '0;
      first_err_addr <= '0;
      first_err_got  <= '0;
      first_err_exp  <= '0;
    end else begin
      state   <= state_next;
      pc_prev <= pc;
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            cycle_cnt      <= '0;
            stable_cnt     <= '0;
            scan_cnt       <= '0;
            timed_out      <= 1'b0;
            err_count      <= '0;
            first_err_addr <= '0;
            first_err_got  <= '0;
            first_err_exp  <= '0;
          end
        end
        S_WAIT: begin
          cycle_cnt  <= cycle_cnt + TCW'(1);
          stable_cnt <= pc_same ? stable_cnt + SW'(1) : '0;
          // Halt takes priority over a timeout landing in the same cycle.
          if (tmo_hit && !halt) timed_out <= 1'b1;
          if (halt || tmo_hit) begin
            scan_cnt <= '0;
            rf_raddr <= tab_addr[0];
          end
        end
        S_SCAN: begin
          if (!scan_last) scan_cnt <= scan_cnt + CW'(1);
          if (scan_cnt < CW'(NCHECK - 1)) rf_raddr <= tab_addr[iss_idx];
          if (mismatch) begin
            if (err_count != CW'(NCHECK)) err_count <= err_count + CW'(1);
            if (err_count == '0) begin
              first_err_addr <= tab_addr[cmp_idx];
              first_err_got  <= rf_rdata;
              first_err_exp  <= tab_data[cmp_idx];
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_checker.sv
module tb_regfile_checker;

  localparam int NCHECK = 8;
  localparam int TMO    = 50;
  // WAIT length for the stalling pc: stalls at cycle 20, first repeat at 21,
  // three equal comparisons (21..23), SCAN from cycle 24.
  localparam int W_HALT = 24;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [31:0] pc;
  logic        cfg_we;
  logic [2:0]  cfg_idx;
  logic        cfg_en;
  logic [4:0]  cfg_addr;
  logic [31:0] cfg_data;
  logic [4:0]  rf_raddr;
  logic [31:0] rf_rdata;
  logic        busy, done, pass, timed_out;
  logic [3:0]  err_count;
  logic [4:0]  first_err_addr;
  logic [31:0] first_err_got, first_err_exp;

  int errors = 0;
  int checks = 0;

  regfile_checker #(
    .XLEN(32), .NREG(32), .NCHECK(NCHECK), .HALT_STABLE(4), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .pc(pc),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_en(cfg_en), .cfg_addr(cfg_addr),
    .cfg_data(cfg_data), .rf_raddr(rf_raddr), .rf_rdata(rf_rdata),
    .busy(busy), .done(done), .pass(pass), .timed_out(timed_out),
    .err_count(err_count), .first_err_addr(first_err_addr),
    .first_err_got(first_err_got), .first_err_exp(first_err_exp)
  );

  always #5 clk = ~clk;

  // Model register file with one-cycle read latency.
  logic [31:0] rf_model [32];
  always_ff @(posedge clk) rf_rdata <= rf_model[rf_raddr];

  // Bench copy of the expected-value table.
  logic        tm_en   [NCHECK];
  logic [4:0]  tm_addr [NCHECK];
  logic [31:0] tm_data [NCHECK];

  typedef struct {
    int          cycles;
    int          err;
    logic        pass;
    logic        tmo;
    logic [4:0]  faddr;
    logic [31:0] fgot;
    logic [31:0] fexp;
  } exp_t;
  exp_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_model();
    for (int i = 0; i < NCHECK; i++) begin
      tm_en[i] = 1'b0; tm_addr[i] = '0; tm_data[i] = '0;
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_pass"}, 32'(pass), 0);
    chk({tag, "_tmo"}, 32'(timed_out), 0);
    chk({tag, "_err"}, 32'(err_count), 0);
    chk({tag, "_raddr"}, 32'(rf_raddr), 0);
    chk({tag, "_faddr"}, 32'(first_err_addr), 0);
    chk({tag, "_fgot"}, first_err_got, 0);
    chk({tag, "_fexp"}, first_err_exp, 0);
  endtask

  task automatic cfg_write(input logic [2:0] i, input logic e, input logic [4:0] a,
                           input logic [31:0] d);
    cfg_we = 1'b1; cfg_idx = i; cfg_en = e; cfg_addr = a; cfg_data = d;
    @(posedge clk); #1;
    cfg_we = 1'b0;
    tm_en[i] = e; tm_addr[i] = a; tm_data[i] = d;
  endtask

  function automatic logic [31:0] pc_at(input int mode, input int c);
    if (mode == 0) return (c < 20) ? 32'(32'h40 - 4 * (20 - c)) : 32'h40;
    return 32'(32'h100 + 4 * c);
  endfunction

  // mode 0: pc stalls, mode 1: pc runs forever (timeout).
  // inj: table write and start pulse during WAIT. cfg_now: table write in the
  // start cycle. rst_at>0: assert rst during that cycle and abandon the run.
  task automatic run(input string tag, input int mode, input bit inj, input bit cfg_now,
                     input logic [2:0] ci, input logic ce, input logic [4:0] ca,
                     input logic [31:0] cd, input int rst_at);
    exp_t e;
    exp_t got_e;
    int   n;
    if (cfg_now) begin
      tm_en[ci] = ce; tm_addr[ci] = ca; tm_data[ci] = cd;
    end
    e.cycles = ((mode == 0) ? W_HALT : TMO) + NCHECK + 1;
    e.err = 0; e.tmo = (mode != 0); e.faddr = '0; e.fgot = '0; e.fexp = '0;
    for (int i = 0; i < NCHECK; i++) begin
      if (tm_en[i] && rf_model[tm_addr[i]] !== tm_data[i]) begin
        if (e.err == 0) begin
          e.faddr = tm_addr[i]; e.fgot = rf_model[tm_addr[i]]; e.fexp = tm_data[i];
        end
        e.err++;
      end
    end
    e.pass = (e.err == 0) && !e.tmo;
    sb.push_back(e);

    start = 1'b1; pc = 32'hFFFF_0000;
    cfg_we = cfg_now; cfg_idx = ci; cfg_en = ce; cfg_addr = ca; cfg_data = cd;
    @(posedge clk); #1;
    start = 1'b0; cfg_we = 1'b0;
    chk({tag, "_start_busy"}, 32'(busy), 1);
    chk({tag, "_start_done"}, 32'(done), 0);
    chk({tag, "_start_err"}, 32'(err_count), 0);
    chk({tag, "_start_faddr"}, 32'(first_err_addr), 0);
    chk({tag, "_start_fgot"}, first_err_got, 0);
    n = 0;
    pc = pc_at(mode, 0);
    while (done !== 1'b1 && n < 200) begin
      if (rst_at > 0 && n == rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        void'(sb.pop_front());
        clear_model();
        return;
      end
      if (inj && n == 2) begin
        cfg_we = 1'b1; cfg_idx = 3'd0; cfg_en = 1'b1; cfg_addr = 5'd21;
        cfg_data = 32'd99; start = 1'b1;
      end else begin
        cfg_we = 1'b0; start = 1'b0;
      end
      @(posedge clk); #1;
      n++;
      pc = pc_at(mode, n);
    end
    cfg_we = 1'b0; start = 1'b0;
    got_e = sb.pop_front();
    chk({tag, "_cycles"}, 32'(n), 32'(got_e.cycles));
    chk({tag, "_busy_end"}, 32'(busy), 0);
    chk({tag, "_err"}, 32'(err_count), 32'(got_e.err));
    chk({tag, "_pass"}, 32'(pass), 32'(got_e.pass));
    chk({tag, "_tmo"}, 32'(timed_out), 32'(got_e.tmo));
    chk({tag, "_faddr"}, 32'(first_err_addr), 32'(got_e.faddr));
    chk({tag, "_fgot"}, first_err_got, got_e.fgot);
    chk({tag, "_fexp"}, first_err_exp, got_e.fexp);
    $display("run %s: cycles=%0d err=%0d pass=%0b tmo=%0b first=x%0d got=0x%0h exp=0x%0h",
             tag, n, err_count, pass, timed_out, first_err_addr, first_err_got, first_err_exp);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; pc = '0;
    cfg_we = 1'b0; cfg_idx = '0; cfg_en = 1'b0; cfg_addr = '0; cfg_data = '0;
    for (int i = 0; i < 32; i++) rf_model[i] = '0;
    clear_model();
    repeat (3) @(posedge clk);
    #1;
    check_reset("reset");
    rst = 1'b0;

    // Table load and matching register file.
    cfg_write(3'd0, 1'b1, 5'd21, 32'd1);
    cfg_write(3'd1, 1'b1, 5'd20, 32'd2);
    cfg_write(3'd2, 1'b1, 5'd19, 32'd3);
    cfg_write(3'd3, 1'b1, 5'd18, 32'd4);
    cfg_write(3'd4, 1'b1, 5'd9,  32'd5);
    cfg_write(3'd5, 1'b1, 5'd8,  32'd6);
    rf_model[21] = 1; rf_model[20] = 2; rf_model[19] = 3;
    rf_model[18] = 4; rf_model[9]  = 5; rf_model[8]  = 6;
    run("match", 0, 0, 0, '0, 0, '0, '0, 0);

    // Two mismatches, first at x19.
    rf_model[19] = 7; rf_model[8] = 0;
    run("mismatch", 0, 0, 0, '0, 0, '0, '0, 0);

    // Back-to-back start from DONE clears results; pc never halts.
    rf_model[19] = 3; rf_model[8] = 6;
    run("timeout", 1, 0, 0, '0, 0, '0, '0, 0);

    // Disabled entry with a wrong register value.
    cfg_write(3'd2, 1'b0, 5'd19, 32'd3);
    rf_model[19] = 55;
    run("disabled", 0, 0, 0, '0, 0, '0, '0, 0);

    // Table write and start during WAIT are ignored.
    run("cfg_in_wait", 0, 1, 0, '0, 0, '0, '0, 0);

    // Reset at scan cycle 3 erases the table.
    run("rst_mid", 0, 0, 0, '0, 0, '0, '0, W_HALT + 3);
    check_reset("rst_mid_reset");
    rf_model[21] = 0;
    run("empty", 0, 0, 0, '0, 0, '0, '0, 0);

    // Same-cycle start and table write; register 0 is compared normally.
    rf_model[0] = 32'h33;
    run("start_cfg_x0", 0, 0, 1, 3'd0, 1'b1, 5'd0, 32'd77, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
